// File: rtl/sort_calc_pkg.sv
// Shared types for the streaming sort-and-compute block:
// result-select mode encoding and control FSM states.
package sort_calc_pkg;

  typedef enum logic [2:0] {
    MODE_SUM_LO   = 3'd0,
    MODE_DIFF_LO  = 3'd1,
    MODE_DIFF_HI  = 3'd2,
    MODE_SPAN_NEG = 3'd3,
    MODE_SUM_HI   = 3'd4,
    MODE_SPAN     = 3'd5,
    MODE_MED_SUM  = 3'd6,
    MODE_RSVD     = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC
  } state_e;

endpackage

// File: rtl/sort_insert.sv
// One-step insertion sorter: inserts v into ascending s[0..cnt-1].
// Ports: s (array), cnt (valid entries), v (sample) -> s_nxt.
module sort_insert
  import sort_calc_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic [N-1:0][W-1:0]       s,
  input  logic [$clog2(N+1)-1:0]    cnt,
  input  logic [W-1:0]              v,
  output logic [N-1:0][W-1:0]       s_nxt
);

  logic [N-1:0]         gt;
  logic [N-1:0]         gt_prev;
  logic [N-1:0][W-1:0]  s_prev;

  // gt is monotonic over the sorted prefix, so the
  // first set bit marks the landing slot of v.
  always_comb begin
    gt = '0;
    for (int i = 0; i < N; i++) begin
      gt[i] = (i < int'(cnt)) &&
              ($signed(s[i]) > $signed(v));
    end
  end

  assign gt_prev = {gt[N-2:0], 1'b0};
  assign s_prev  = {s[N-2:0], {W{1'b0}}};

  always_comb begin
    s_nxt = '0;
    for (int i = 0; i < N; i++) begin
      if ((i < int'(cnt)) && !gt[i])
        s_nxt[i] = s[i];
      else if (gt_prev[i])
        s_nxt[i] = s_prev[i];
      else
        s_nxt[i] = v;
    end
  end

endmodule

// File: rtl/sort_calc_n.sv
// Serial N-sample sorter with one order-statistic result per frame.
// Ports: clk, rst, in_valid/in_number/mode -> out_valid/out_result/out_err.
module sort_calc_n
  import sort_calc_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [W-1:0]        in_number,
  input  logic [2:0]          mode,
  output logic                out_valid,
  output logic [W+1:0]        out_result,
  output logic                out_err
);

  localparam int CW = $clog2(N + 1);
  localparam int RW = W + 2;

  state_e               state;
  state_e               state_nxt;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        ins_cnt;
  logic [N-1:0][W-1:0]  s;
  logic [N-1:0][W-1:0]  s_ins;
  mode_e                mode_q;
  logic                 take;
  logic                 first;
  logic                 abort;
  logic                 fire;
  logic [RW-1:0]        res;
  logic                 rerr;

  function automatic logic [RW-1:0] sx(
    input logic [W-1:0] x
  );
    return {{2{x[W-1]}}, x};
  endfunction

  // A beat seen during CALC opens the next frame;
  // the result still uses the pre-edge array.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    first     = 1'b0;
    abort     = 1'b0;
    fire      = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          take      = 1'b1;
          first     = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          take = 1'b1;
          if (cnt == CW'(N - 1))
            state_nxt = CALC;
        end else begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      CALC: begin
        fire      = 1'b1;
        state_nxt = IDLE;
        if (in_valid) begin
          take      = 1'b1;
          first     = 1'b1;
          state_nxt = LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ins_cnt = first ? '0 : cnt;

  sort_insert #(
    .W (W),
    .N (N)
  ) u_ins (
    .s     (s),
    .cnt   (ins_cnt),
    .v     (in_number),
    .s_nxt (s_ins)
  );

  always_comb begin
    res  = '0;
    rerr = 1'b0;
    unique case (mode_q)
      MODE_SUM_LO:   res = sx(s[0]) + sx(s[1]);
      MODE_DIFF_LO:  res = sx(s[1]) - sx(s[0]);
      MODE_DIFF_HI:  res = sx(s[N-1]) - sx(s[N-2]);
      MODE_SPAN_NEG: res = sx(s[0]) - sx(s[N-1]);
      MODE_SUM_HI:   res = sx(s[N-1]) + sx(s[N-2]);
      MODE_SPAN:     res = sx(s[N-1]) - sx(s[0]);
      MODE_MED_SUM:  res = sx(s[N/2-1]) + sx(s[N/2]);
      MODE_RSVD:     rerr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s          <= '0;
      cnt        <= '0;
      mode_q     <= MODE_SUM_LO;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_err    <= 1'b0;
    end else begin
      out_valid  <= fire;
      out_result <= fire ? res : '0;
      out_err    <= abort | (fire & rerr);
      if (take) begin
        s   <= s_ins;
        cnt <= first ? CW'(1) : cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (first)
        mode_q <= mode_e'(mode);
    end
  end

endmodule

// File: tb/tb_sort_calc_n.sv
// Directed + randomized check of sort_calc_n at N=4/W=4 and N=8/W=6.
// Both instances share one clock; expectations are hand values or a model.
module tb_sort_calc_n;

  logic       clk = 1'b0;
  logic       rst4, rst8;
  logic       iv4, iv8;
  logic [3:0] in4;
  logic [5:0] in8;
  logic [2:0] md4, md8;
  logic       ov4, ov8;
  logic [5:0] res4;
  logic [7:0] res8;
  logic       er4, er8;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  sort_calc_n #(.W(4), .N(4)) dut4 (
    .clk        (clk),
    .rst        (rst4),
    .in_valid   (iv4),
    .in_number  (in4),
    .mode       (md4),
    .out_valid  (ov4),
    .out_result (res4),
    .out_err    (er4)
  );

  sort_calc_n #(.W(6), .N(8)) dut8 (
    .clk        (clk),
    .rst        (rst8),
    .in_valid   (iv8),
    .in_number  (in8),
    .mode       (md8),
    .out_valid  (ov8),
    .out_result (res8),
    .out_err    (er8)
  );

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  function automatic int vld_of(input bit big);
    return big ? int'(ov8) : int'(ov4);
  endfunction

  function automatic int err_of(input bit big);
    return big ? int'(er8) : int'(er4);
  endfunction

  function automatic int res_of(input bit big);
    return big ? int'($signed(res8))
               : int'($signed(res4));
  endfunction

  task automatic drive(input bit big, input bit vld,
                       input int v, input int m);
    if (big) begin
      iv8 = vld; in8 = 6'(v); md8 = 3'(m);
    end else begin
      iv4 = vld; in4 = 4'(v); md4 = 3'(m);
    end
  endtask

  function automatic int model(input int m,
                               input int a[8],
                               input int n);
    int s[8];
    int t;
    s = a;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n - 1 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    case (m)
      0: return s[0] + s[1];
      1: return s[1] - s[0];
      2: return s[n-1] - s[n-2];
      3: return s[0] - s[n-1];
      4: return s[n-1] + s[n-2];
      5: return s[n-1] - s[0];
      6: return s[n/2-1] + s[n/2];
      default: return 0;
    endcase
  endfunction

  // Later beats carry a random mode that must be ignored.
  task automatic run_frame(input bit big, input int m,
                           input int v[8], input int nb,
                           input int exp_res,
                           input bit exp_err,
                           input string tag);
    int n;
    n = big ? 8 : 4;
    for (int i = 0; i < nb; i++) begin
      drive(big, 1'b1, v[i],
            (i == 0) ? m : int'($urandom_range(0, 7)));
      @(posedge clk); #1;
    end
    drive(big, 1'b0, 0, int'($urandom_range(0, 7)));
    if (nb == n) begin
      check({tag, "_lat"}, vld_of(big), 0);
      @(posedge clk); #1;
      check({tag, "_vld"}, vld_of(big), 1);
      check({tag, "_res"}, res_of(big), exp_res);
      check({tag, "_err"}, err_of(big), int'(exp_err));
      @(posedge clk); #1;
      check({tag, "_vld0"}, vld_of(big), 0);
      check({tag, "_res0"}, res_of(big), 0);
      check({tag, "_err0"}, err_of(big), 0);
    end else begin
      @(posedge clk); #1;
      check({tag, "_abort_err"}, err_of(big), 1);
      check({tag, "_abort_vld"}, vld_of(big), 0);
      @(posedge clk); #1;
      check({tag, "_abort_err0"}, err_of(big), 0);
      check({tag, "_abort_vld0"}, vld_of(big), 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int v[8];
    int m;
    rst4 = 1'b1; rst8 = 1'b1;
    drive(1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld4", int'(ov4), 0);
    check("rst_res4", res_of(1'b0), 0);
    check("rst_err4", int'(er4), 0);
    check("rst_vld8", int'(ov8), 0);
    rst4 = 1'b0; rst8 = 1'b0;
    @(posedge clk); #1;

    v = '{7, -8, 3, -1, 0, 0, 0, 0};
    run_frame(1'b0, 0, v, 4, -9, 1'b0, "m0");
    run_frame(1'b0, 3, v, 4, -15, 1'b0, "m3");
    run_frame(1'b0, 5, v, 4, 15, 1'b0, "m5");
    run_frame(1'b0, 6, v, 4, 2, 1'b0, "m6");

    v = '{7, 7, 7, 7, 0, 0, 0, 0};
    run_frame(1'b0, 4, v, 4, 14, 1'b0, "tie_hi");
    v = '{-8, -8, -8, -8, 0, 0, 0, 0};
    run_frame(1'b0, 1, v, 4, 0, 1'b0, "tie_lo");

    v = '{3, -2, 0, 0, 0, 0, 0, 0};
    run_frame(1'b0, 2, v, 2, 0, 1'b0, "ab");
    v = '{1, 5, 2, 4, 0, 0, 0, 0};
    run_frame(1'b0, 2, v, 4, 1, 1'b0, "m2");

    v = '{2, -3, 6, 1, 0, 0, 0, 0};
    run_frame(1'b0, 7, v, 4, 0, 1'b1, "rsvd");

    // Reset mid-frame: partial frame lost, no error.
    v = '{5, -7, 9, 0, 2, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, v[i], 5);
      @(posedge clk); #1;
    end
    rst8 = 1'b1;
    drive(1'b1, 1'b0, 0, 0);
    #1;
    check("rstmid_vld", int'(ov8), 0);
    check("rstmid_err", int'(er8), 0);
    @(posedge clk); #1;
    check("rstmid_err2", int'(er8), 0);
    rst8 = 1'b0;
    @(posedge clk); #1;

    v = '{-32, 31, 0, 0, 1, 2, 3, 4};
    run_frame(1'b1, 5, v, 8, 63, 1'b0, "w8_span");

    // Reset while the result is on the outputs.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, v[i], 0);
      @(posedge clk); #1;
    end
    drive(1'b1, 1'b0, 0, 0);
    @(posedge clk); #1;
    check("rstout_vld1", int'(ov8), 1);
    #2 rst8 = 1'b1;
    #1;
    check("rstout_vld", int'(ov8), 0);
    check("rstout_res", res_of(1'b1), 0);
    @(posedge clk); #1;
    rst8 = 1'b0;
    @(posedge clk); #1;

    for (int f = 0; f < 500; f++) begin
      for (int i = 0; i < 8; i++)
        v[i] = int'($urandom_range(0, 63)) - 32;
      m = int'($urandom_range(0, 7));
      run_frame(1'b1, m, v, 8, model(m, v, 8),
                (m == 7), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
